// File: rtl/trace_pkg.sv
// Shared types for the commit-trace collector: record layout and LSU size codes.
package trace_pkg;

    localparam int XLEN_DFLT = 32;
    localparam int CORE_W    = 8;

    localparam logic [1:0] LSU_SIZ_B = 2'd0;
    localparam logic [1:0] LSU_SIZ_H = 2'd1;
    localparam logic [1:0] LSU_SIZ_W = 2'd2;
    localparam logic [1:0] LSU_SIZ_D = 2'd3;

    // Record fields are sized by XLEN_DFLT; collectors must be built with XLEN == XLEN_DFLT.
    typedef struct packed {
        logic [CORE_W-1:0]    core;
        logic [XLEN_DFLT-1:0] ifu_adr;
        logic [XLEN_DFLT-1:0] ifu_ins;
        logic                 wbu_ena;
        logic [4:0]           wbu_idx;
        logic [XLEN_DFLT-1:0] wbu_dat;
        logic                 lsu_ena;
        logic                 lsu_wen;
        logic                 lsu_ren;
        logic [XLEN_DFLT-1:0] lsu_adr;
        logic [1:0]           lsu_siz;
        logic [XLEN_DFLT-1:0] lsu_wdt;
    } trace_rec_t;

endpackage

// File: rtl/trace_commit_collector_if.sv
// Observed core buses plus the record stream of the commit-trace collector.
interface trace_commit_collector_if
    import trace_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
);
    logic            ifu_vld;
    logic            ifu_rdy;
    logic [XLEN-1:0] ifu_adr;
    logic [XLEN-1:0] ifu_rdt;
    logic            ifu_flush;
    logic            ret_vld;
    logic            wbu_ena;
    logic [4:0]      wbu_idx;
    logic [XLEN-1:0] wbu_dat;
    logic            lsu_vld;
    logic            lsu_rdy;
    logic            lsu_wen;
    logic            lsu_ren;
    logic [XLEN-1:0] lsu_adr;
    logic [1:0]      lsu_siz;
    logic [XLEN-1:0] lsu_wdt;
    logic            trc_vld;
    logic            trc_rdy;
    trace_rec_t      trc_rec;

    modport master (
        output ifu_vld, ifu_rdy, ifu_adr, ifu_rdt, ifu_flush,
        output ret_vld, wbu_ena, wbu_idx, wbu_dat,
        output lsu_vld, lsu_rdy, lsu_wen, lsu_ren, lsu_adr, lsu_siz, lsu_wdt,
        output trc_rdy,
        input  trc_vld, trc_rec
    );

    modport slave (
        input  ifu_vld, ifu_rdy, ifu_adr, ifu_rdt, ifu_flush,
        input  ret_vld, wbu_ena, wbu_idx, wbu_dat,
        input  lsu_vld, lsu_rdy, lsu_wen, lsu_ren, lsu_adr, lsu_siz, lsu_wdt,
        input  trc_rdy,
        output trc_vld, trc_rec
    );

endinterface

// File: rtl/trace_fifo.sv
// Small synchronous FIFO with simultaneous push/pop and a clear that may coexist with a push.
module trace_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clr_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_adr;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign rd_en   = pop_i & ~empty_o;
    // When full, a write is only safe if the head leaves in the same cycle.
    assign wr_en   = push_i & (clr_i | ~full_o | rd_en);
    assign wr_adr  = clr_i ? '0 : wr_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = wr_en ? AW'(1) : '0;
            cnt_d    = wr_en ? (AW+1)'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_adr] <= din_i;
    end

endmodule

// File: rtl/trace_commit_collector.sv
// Observes IFU fetches and retirements and emits one commit record per retired instruction.
module trace_commit_collector
    import trace_pkg::*;
#(
    parameter int XLEN  = XLEN_DFLT,
    parameter int DLY   = 1,
    parameter int DEPTH = 4,
    parameter int CORE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    trace_commit_collector_if.slave  bus,
    output logic [63:0]              ret_cnt,
    output logic                     err_ovf,
    output logic                     err_unf
);
    localparam bit HAS_DLY = (DLY > 0);

    logic              hs;
    logic              dl_vld;
    logic [XLEN-1:0]   dl_adr;
    logic              f_push, f_pop, f_full, f_empty;
    logic [2*XLEN-1:0] f_dout;
    logic              bypass, rsp_ok, fetch_drop, rec_drop, unf, held;
    logic [2*XLEN-1:0] ins_src;
    trace_rec_t        new_rec;

    logic              trc_vld_q, trc_vld_d;
    trace_rec_t        trc_rec_q, trc_rec_d;
    logic [63:0]       ret_cnt_q, ret_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    assign hs = bus.ifu_vld & bus.ifu_rdy;

    // Address delay line: aligns each fetch address with its late response data.
    if (DLY == 0) begin : g_nodly
        assign dl_vld = hs;
        assign dl_adr = bus.ifu_adr;
    end else begin : g_dly
        logic [DLY-1:0]  dvld_q, dvld_d;
        logic [XLEN-1:0] dadr_q [DLY];

        // A handshake in the flush cycle belongs to the redirected stream, so stage 0 keeps it.
        always_comb begin
            dvld_d    = '0;
            dvld_d[0] = hs;
            for (int i = 1; i < DLY; i++) dvld_d[i] = dvld_q[i-1] & ~bus.ifu_flush;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) dvld_q <= '0;
            else      dvld_q <= dvld_d;
        end

        always_ff @(posedge clk) begin
            dadr_q[0] <= bus.ifu_adr;
            for (int i = 1; i < DLY; i++) dadr_q[i] <= dadr_q[i-1];
        end

        assign dl_vld = dvld_q[DLY-1];
        assign dl_adr = dadr_q[DLY-1];
    end

    // With DLY=0 the response is the flush-cycle handshake itself and must survive the flush.
    assign rsp_ok     = dl_vld & (~bus.ifu_flush | ~HAS_DLY);
    assign bypass     = HAS_DLY & bus.ret_vld & f_empty & dl_vld;
    assign f_pop      = bus.ret_vld & ~f_empty;
    assign f_push     = rsp_ok & ~bypass;
    assign fetch_drop = f_push & f_full & ~f_pop & ~bus.ifu_flush;
    assign unf        = bus.ret_vld & f_empty & ~bypass;
    assign held       = trc_vld_q & ~bus.trc_rdy;
    assign rec_drop   = bus.ret_vld & held;

    trace_fifo #(
        .W     (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .clr_i   (bus.ifu_flush),
        .din_i   ({dl_adr, bus.ifu_rdt}),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    always_comb begin
        ins_src = '0;
        if (f_pop)       ins_src = f_dout;
        else if (bypass) ins_src = {dl_adr, bus.ifu_rdt};
    end

    always_comb begin
        new_rec         = '0;
        new_rec.core    = CORE_W'(CORE);
        new_rec.ifu_adr = ins_src[2*XLEN-1:XLEN];
        new_rec.ifu_ins = ins_src[XLEN-1:0];
        new_rec.wbu_ena = bus.wbu_ena;
        new_rec.wbu_idx = bus.wbu_idx;
        new_rec.wbu_dat = bus.wbu_dat;
        new_rec.lsu_ena = bus.lsu_vld & bus.lsu_rdy;
        new_rec.lsu_wen = bus.lsu_wen;
        new_rec.lsu_ren = bus.lsu_ren;
        new_rec.lsu_adr = bus.lsu_adr;
        new_rec.lsu_siz = bus.lsu_siz;
        new_rec.lsu_wdt = bus.lsu_wdt;
    end

    // Output register: a retire against a stalled record is counted but its record is lost.
    always_comb begin
        trc_vld_d = trc_vld_q;
        trc_rec_d = trc_rec_q;
        if (bus.ret_vld && !held) begin
            trc_vld_d = 1'b1;
            trc_rec_d = new_rec;
        end else if (bus.trc_rdy) begin
            trc_vld_d = 1'b0;
        end
        ret_cnt_d = ret_cnt_q + 64'(bus.ret_vld);
        err_ovf_d = err_ovf_q | fetch_drop | rec_drop;
        err_unf_d = err_unf_q | unf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trc_vld_q <= 1'b0;
            trc_rec_q <= '0;
            ret_cnt_q <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            trc_vld_q <= trc_vld_d;
            trc_rec_q <= trc_rec_d;
            ret_cnt_q <= ret_cnt_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign bus.trc_vld = trc_vld_q;
    assign bus.trc_rec = trc_rec_q;
    assign ret_cnt     = ret_cnt_q;
    assign err_ovf     = err_ovf_q;
    assign err_unf     = err_unf_q;

endmodule

// File: tb/tb_trace_commit_collector.sv
// Bench for trace_commit_collector: vector table plus scoreboarded corner-case sequences.
module tb_trace_commit_collector;
    import trace_pkg::*;

    localparam int XLEN  = 32;
    localparam int DLY   = 1;
    localparam int DEPTH = 4;
    localparam int CORE  = 3;

    logic        clk;
    logic        rst;
    logic [63:0] ret_cnt;
    logic        err_ovf;
    logic        err_unf;

    trace_commit_collector_if #(.XLEN(XLEN)) bus ();

    trace_commit_collector #(
        .XLEN  (XLEN),
        .DLY   (DLY),
        .DEPTH (DEPTH),
        .CORE  (CORE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ret_cnt (ret_cnt),
        .err_ovf (err_ovf),
        .err_unf (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] ins;
        logic        wena;
        logic [4:0]  widx;
        logic [31:0] wdat;
        logic        lvld;
        logic        lrdy;
        logic        lwen;
        logic        lren;
        logic [31:0] ladr;
        logic [1:0]  lsiz;
        logic [31:0] lwdt;
        logic        exp_lena;
        logic [63:0] exp_cnt;
    } vec_t;

    vec_t        vecs[4];
    trace_rec_t  exp_q[$];
    trace_rec_t  mon_exp;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] cnt_model = 0;

    function automatic trace_rec_t mk(input logic [31:0] adr, input logic [31:0] ins,
                                      input logic wena, input logic [4:0] widx,
                                      input logic [31:0] wdat, input logic lena,
                                      input logic lwen, input logic lren,
                                      input logic [31:0] ladr, input logic [1:0] lsiz,
                                      input logic [31:0] lwdt);
        trace_rec_t r;
        r         = '0;
        r.core    = 8'(CORE);
        r.ifu_adr = adr;
        r.ifu_ins = ins;
        r.wbu_ena = wena;
        r.wbu_idx = widx;
        r.wbu_dat = wdat;
        r.lsu_ena = lena;
        r.lsu_wen = lwen;
        r.lsu_ren = lren;
        r.lsu_adr = ladr;
        r.lsu_siz = lsiz;
        r.lsu_wdt = lwdt;
        return r;
    endfunction

    function automatic trace_rec_t mk_plain(input logic [31:0] adr, input logic [31:0] ins);
        return mk(adr, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_vld   = 1'b0;
        bus.ifu_rdy   = 1'b0;
        bus.ifu_adr   = '0;
        bus.ifu_rdt   = '0;
        bus.ifu_flush = 1'b0;
        bus.ret_vld   = 1'b0;
        bus.wbu_ena   = 1'b0;
        bus.wbu_idx   = '0;
        bus.wbu_dat   = '0;
        bus.lsu_vld   = 1'b0;
        bus.lsu_rdy   = 1'b0;
        bus.lsu_wen   = 1'b0;
        bus.lsu_ren   = 1'b0;
        bus.lsu_adr   = '0;
        bus.lsu_siz   = '0;
        bus.lsu_wdt   = '0;
    endtask

    // Handshake in one cycle, response data in the next (DLY = 1).
    task automatic fetch(input logic [31:0] a, input logic [31:0] i);
        bus.ifu_vld = 1'b1;
        bus.ifu_rdy = 1'b1;
        bus.ifu_adr = a;
        tick();
        bus.ifu_vld = 1'b0;
        bus.ifu_rdy = 1'b0;
        bus.ifu_rdt = i;
        tick();
        bus.ifu_rdt = '0;
    endtask

    task automatic retire(input logic wena, input logic [4:0] widx, input logic [31:0] wdat,
                          input logic lvld, input logic lrdy, input logic lwen, input logic lren,
                          input logic [31:0] ladr, input logic [1:0] lsiz, input logic [31:0] lwdt);
        bus.ret_vld = 1'b1;
        bus.wbu_ena = wena;
        bus.wbu_idx = widx;
        bus.wbu_dat = wdat;
        bus.lsu_vld = lvld;
        bus.lsu_rdy = lrdy;
        bus.lsu_wen = lwen;
        bus.lsu_ren = lren;
        bus.lsu_adr = ladr;
        bus.lsu_siz = lsiz;
        bus.lsu_wdt = lwdt;
        tick();
        bus.ret_vld = 1'b0;
        bus.wbu_ena = 1'b0;
        bus.lsu_vld = 1'b0;
        bus.lsu_rdy = 1'b0;
        bus.lsu_wen = 1'b0;
        bus.lsu_ren = 1'b0;
        cnt_model++;
    endtask

    task automatic retire_plain();
        retire(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every accepted record must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.trc_vld === 1'b1 && bus.trc_rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record actual adr 0x%0h ins 0x%0h required none",
                         bus.trc_rec.ifu_adr, bus.trc_rec.ifu_ins);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.trc_rec !== mon_exp) begin
                    errors++;
                    $display("FAIL record actual 0x%0h required 0x%0h", bus.trc_rec, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'h0000_0005,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 64'd1};
        vecs[1] = '{32'h8000_0004, 32'h0011_2023, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_1000, LSU_SIZ_W, 32'hdead_beef, 1'b1, 64'd2};
        vecs[2] = '{32'h8000_0008, 32'h0000_a103, 1'b1, 5'd2, 32'h1234_5678,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_1000, LSU_SIZ_W, 32'h0, 1'b1, 64'd3};
        vecs[3] = '{32'h8000_000c, 32'h0020_8023, 1'b0, 5'd0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_1004, LSU_SIZ_B, 32'h0000_00ff, 1'b0, 64'd4};

        idle_inputs();
        bus.trc_rdy = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_trc_vld", 64'(bus.trc_vld), 64'd0);
        check("reset_trc_rec_adr", 64'(bus.trc_rec.ifu_adr), 64'd0);
        check("reset_ret_cnt", ret_cnt, 64'd0);
        check("reset_err_ovf", 64'(err_ovf), 64'd0);
        check("reset_err_unf", 64'(err_unf), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            fetch(vecs[v].adr, vecs[v].ins);
            exp_q.push_back(mk(vecs[v].adr, vecs[v].ins, vecs[v].wena, vecs[v].widx, vecs[v].wdat,
                               vecs[v].exp_lena, vecs[v].lwen, vecs[v].lren, vecs[v].ladr,
                               vecs[v].lsiz, vecs[v].lwdt));
            retire(vecs[v].wena, vecs[v].widx, vecs[v].wdat, vecs[v].lvld, vecs[v].lrdy,
                   vecs[v].lwen, vecs[v].lren, vecs[v].ladr, vecs[v].lsiz, vecs[v].lwdt);
            drain("vec_drain");
            check("vec_ret_cnt", ret_cnt, vecs[v].exp_cnt);
        end

        // Bypass: retire in the same cycle the response arrives, FIFO empty.
        bus.ifu_vld = 1'b1;
        bus.ifu_rdy = 1'b1;
        bus.ifu_adr = 32'h0000_0400;
        tick();
        bus.ifu_vld = 1'b0;
        bus.ifu_rdy = 1'b0;
        bus.ifu_rdt = 32'h0070_0113;
        exp_q.push_back(mk(32'h400, 32'h0070_0113, 1'b1, 5'd2, 32'h7,
                           1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0));
        retire(1'b1, 5'd2, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        bus.ifu_rdt = '0;
        drain("bypass_drain");
        check("bypass_err_unf", 64'(err_unf), 64'd0);

        // Flush with retire and a new-stream handshake in the same cycle.
        fetch(32'h100, 32'h1111_0001);
        fetch(32'h104, 32'h1111_0002);
        fetch(32'h108, 32'h1111_0003);
        bus.ifu_flush = 1'b1;
        bus.ifu_vld   = 1'b1;
        bus.ifu_rdy   = 1'b1;
        bus.ifu_adr   = 32'h200;
        exp_q.push_back(mk_plain(32'h100, 32'h1111_0001));
        retire_plain();
        bus.ifu_flush = 1'b0;
        bus.ifu_vld   = 1'b0;
        bus.ifu_rdy   = 1'b0;
        bus.ifu_rdt   = 32'h2222_0001;
        tick();
        bus.ifu_rdt = '0;
        exp_q.push_back(mk_plain(32'h200, 32'h2222_0001));
        retire_plain();
        drain("flush_drain");
        check("flush_err_ovf", 64'(err_ovf), 64'd0);
        check("flush_err_unf", 64'(err_unf), 64'd0);
        check("flush_ret_cnt", ret_cnt, cnt_model);

        // Backpressure: second retire while the first record is stalled is dropped.
        bus.trc_rdy = 1'b0;
        fetch(32'h300, 32'h3333_0001);
        fetch(32'h304, 32'h3333_0002);
        exp_q.push_back(mk_plain(32'h300, 32'h3333_0001));
        retire_plain();
        retire_plain();
        check("bp_err_ovf", 64'(err_ovf), 64'd1);
        check("bp_ret_cnt", ret_cnt, cnt_model);
        check("bp_trc_vld_held", 64'(bus.trc_vld), 64'd1);
        check("bp_held_adr", 64'(bus.trc_rec.ifu_adr), 64'h300);
        bus.trc_rdy = 1'b1;
        tick();
        check("bp_trc_vld_fall", 64'(bus.trc_vld), 64'd0);
        drain("bp_drain");

        // Asynchronous reset with a pending record and a non-empty FIFO.
        bus.trc_rdy = 1'b0;
        fetch(32'h500, 32'h5555_0001);
        fetch(32'h504, 32'h5555_0002);
        retire_plain();
        check("mid_trc_vld_before", 64'(bus.trc_vld), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_trc_vld", 64'(bus.trc_vld), 64'd0);
        check("mid_trc_rec", 64'(bus.trc_rec.ifu_adr | bus.trc_rec.ifu_ins), 64'd0);
        check("mid_ret_cnt", ret_cnt, 64'd0);
        check("mid_err_ovf", 64'(err_ovf), 64'd0);
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.trc_rdy = 1'b1;
        tick();
        fetch(32'h600, 32'h6666_0001);
        exp_q.push_back(mk_plain(32'h600, 32'h6666_0001));
        retire_plain();
        drain("mid_drain");
        check("mid_ret_cnt_after", ret_cnt, 64'd1);

        // FIFO overflow, then underflow once the four kept entries are consumed.
        for (int k = 0; k < 4; k++) fetch(32'h1000 + 32'(k * 4), 32'hA000_0000 + 32'(k));
        check("full_no_ovf_yet", 64'(err_ovf), 64'd0);
        fetch(32'h1010, 32'hA000_0004);
        check("full_err_ovf", 64'(err_ovf), 64'd1);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk_plain(32'h1000 + 32'(k * 4), 32'hA000_0000 + 32'(k)));
            retire_plain();
        end
        check("full_no_unf_yet", 64'(err_unf), 64'd0);
        exp_q.push_back(mk_plain(32'h0, 32'h0));
        retire_plain();
        check("unf_err_unf", 64'(err_unf), 64'd1);
        drain("full_drain");
        check("full_ret_cnt", ret_cnt, cnt_model);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_commit_collector.md
# trace_commit_collector

Monitor-side collector that assembles one complete per-instruction commit record from the core's IFU TCB fetch transfers, its retirement strobe with GPR write-back, and the LSU TCB request issued at retirement. Records are presented on a valid/ready stream that feeds the Spike-format trace string formatter in the RISCOF testbench. The collector is purely observational: it never drives the observed buses.

## Interface
Parameters:
- XLEN, 32, data/address width
- DLY, 1, IFU TCB response delay in cycles after request handshake; legal 0..2
- DEPTH, 4, fetch FIFO depth (power of two, ≥2)
- CORE, 0, hart index copied into every record

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- ifu_vld  in  1  IFU TCB request valid
- ifu_rdy  in  1  IFU TCB request ready
- ifu_adr  in  XLEN  fetch address (sampled at handshake)
- ifu_rdt  in  XLEN  fetched instruction, valid DLY cycles after handshake
- ifu_flush  in  1  pipeline redirect; discards fetched, unretired instructions
- ret_vld  in  1  one instruction retires this cycle
- wbu_ena, wbu_idx[5], wbu_dat[XLEN]  in  GPR write-back of retiring instruction
- lsu_vld, lsu_rdy, lsu_wen, lsu_ren  in  1 each  LSU TCB request belonging to the retiring instruction
- lsu_adr[XLEN], lsu_siz[2], lsu_wdt[XLEN]  in  LSU request fields
- trc_vld  out  1  record valid
- trc_rdy  in  1  record accepted
- trc_rec  out  trace_rec_t  core, ifu_adr, ifu_ins, wbu_*, lsu_ena/wen/ren/adr/siz/wdt
- ret_cnt  out  64  retired-instruction counter
- err_ovf  out  1  sticky: record or fetch dropped
- err_unf  out  1  sticky: retire with no fetched instruction available

## Operation
- Fetch tracking: each ifu_vld&ifu_rdy pushes adr into a DLY-deep delay line with per-stage valid; at stage DLY, {adr, ifu_rdt} is pushed into the fetch FIFO. DLY=0 pushes in the handshake cycle.
- Retire: ret_vld pops the FIFO head and loads trc_rec with head, wbu_* and lsu_* fields; lsu_ena = lsu_vld&lsu_rdy. If DLY>0 and FIFO empty but the delay-line output is valid this cycle, bypass it directly into the record.
- Retire with no instruction available: record emitted with ifu_adr/ifu_ins = 0, err_unf set.
- Output: single register stage. trc_vld set on retire, cleared on trc_rdy without new retire. Retire while trc_vld&!trc_rdy: new record dropped, old kept, err_ovf set.
- ret_cnt increments on every ret_vld, including dropped records; wraps modulo 2^64.
- FIFO push while full without simultaneous pop: fetch dropped, err_ovf set. Push+pop when full: legal, no error.
- Flush: clears FIFO and all delay-line valids at end of cycle; a response arriving in the flush cycle is discarded. Retire in the flush cycle pops/bypasses first, record emitted normally. Handshake in the flush cycle is kept (belongs to redirected stream).
- err_ovf/err_unf clear only on reset.

## Timing
- Reset (async assert, sync deassert by environment): trc_vld=0, trc_rec=0, ret_cnt=0, err_*=0, FIFO empty, delay line invalid.
- Latency: ret_vld at cycle N → trc_vld=1 with record at N+1.
- Instruction retirable earliest DLY cycles after its fetch handshake (bypass), else from FIFO.
- Throughput: one record per cycle when trc_rdy held high.

## Structure
- Shared package trace_pkg: trace_rec_t packed struct, lsu size encoding constants, XLEN default.
- Sub-module trace_fifo (parameterized width/depth, full/empty, simultaneous push/pop); collector instantiates it once for {adr, ins}.

## Test plan
- DLY=1: fetch 0x80000000 (rdt 0x00500093), retire with wbu x1=0x5 two cycles later → record {0x80000000, 0x00500093, x1, 0x00000005}, ret_cnt=1.
- Store: fetch 0x80000004 (0x00112023), retire with lsu_wen, adr 0x80001000, siz 2, wdt 0xdeadbeef → record lsu_ena=1, wen=1, fields matching; formatter output contains "mem 0x80001000 0xdeadbeef".
- Flush: fetch 0x100, 0x104, 0x108; retire 0x100 with flush in same cycle; fetch 0x200; retire → records 0x100 then 0x200, no errors.
- Backpressure: trc_rdy=0, retire twice → first record held, err_ovf=1, ret_cnt=2; trc_rdy=1 → single record delivered, trc_vld falls.
- FIFO full: DEPTH=4, five fetches no retire → err_ovf=1, subsequent four retires return first four addresses; fifth retire → err_unf=1, ifu_adr=0.
- Reset mid-stream with trc_vld=1 and FIFO non-empty → all outputs zero immediately (async), next fetch/retire pair produces correct record.
